// File: rtl/switch_debounce.sv
// switch_debounce: debounces a raw switch or pushbutton input.
// The raw input is first synchronised. A level change is accepted only after
// the synchronised input has stayed stable for STABLE_TICKS ticks of a
// free-running sample timer.
//
// Output contract (there is no valid/ready handshake):
// - db_level is a registered-state Moore output.
// - db_tick is a one-cycle Mealy strobe. It is high in the cycle that precedes
//   the clock edge at which db_level rises. It has no back-pressure.
module switch_debounce #(
  parameter int TICK_BITS    = 20,
  parameter int STABLE_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw,
  output logic       db_level,
  output logic       db_tick,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  // Stability count value at which the next sample tick accepts the change.
  localparam logic [3:0] LAST_CNT = 4'(STABLE_TICKS - 1);

  logic                 s1_q;
  logic                 s_sync_q;
  logic [TICK_BITS-1:0] timer_q;
  logic                 m_tick;
  state_e               state_q;
  state_e               state_d;
  logic [3:0]           wcnt_q;
  logic [3:0]           wcnt_d;
  logic                 db_tick_d;

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s_sync_q <= 1'b0;
    end else begin
      s1_q     <= sw;
      s_sync_q <= s1_q;
    end
  end

  // Free-running sample timer. The FSM never clears it, so it keeps its phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign m_tick = &timer_q;

  // State and stability-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ZERO;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic and the Mealy db_tick strobe.
  // A reversal of s_sync is tested first, so it overrides a sample tick
  // that arrives in the same cycle.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    db_tick_d = 1'b0;
    case (state_q)
      ZERO: begin
        if (s_sync_q) begin
          state_d = WAIT1;
          wcnt_d  = 4'd0;
        end
      end
      WAIT1: begin
        if (!s_sync_q) begin
          state_d = ZERO;
        end else if (m_tick && (wcnt_q == LAST_CNT)) begin
          state_d   = ONE;
          db_tick_d = 1'b1;
        end else if (m_tick) begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      ONE: begin
        if (!s_sync_q) begin
          state_d = WAIT0;
          wcnt_d  = 4'd0;
        end
      end
      WAIT0: begin
        if (s_sync_q) begin
          state_d = ONE;
        end else if (m_tick && (wcnt_q == LAST_CNT)) begin
          state_d = ZERO;
        end else if (m_tick) begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
  end

  // db_level is decoded from the state register only, so it cannot glitch.
  assign db_level    = (state_q == ONE) || (state_q == WAIT0);
  assign db_tick     = db_tick_d;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce (TICK_BITS=3).
// The main instance uses STABLE_TICKS=3. A second instance uses STABLE_TICKS=1.
// Stimulus pushes the expected events, with their allowed cycle windows, into
// a queue. A negedge monitor pops one entry for every db_tick pulse and every
// db_level change it observes.
module tb_switch_debounce;

  localparam int W = 34;
  localparam logic [1:0] EV_TICK = 2'd0;
  localparam logic [1:0] EV_RISE = 2'd1;
  localparam logic [1:0] EV_FALL = 2'd2;
  localparam logic [1:0] EV_NONE = 2'd3;
  localparam int ST_ZERO  = 0;
  localparam int ST_WAIT1 = 1;
  localparam int ST_ONE   = 2;
  localparam int ST_WAIT0 = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       sw    = 1'b0;
  logic       sw1   = 1'b0;
  logic       db_level, db_tick, db_level1, db_tick1;
  logic [1:0] st, st1;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];

  switch_debounce #(.TICK_BITS(3), .STABLE_TICKS(3)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(db_level), .db_tick(db_tick), .dbg_state_o(st)
  );

  switch_debounce #(.TICK_BITS(3), .STABLE_TICKS(1)) dut1 (
    .clk(clk), .reset(reset), .sw(sw1),
    .db_level(db_level1), .db_tick(db_tick1), .dbg_state_o(st1)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [1:0] kind, input int lo, input int hi);
    return {kind, lo[15:0], hi[15:0]};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard
  task automatic score(input string name, input logic [W-1:0] it,
                       input logic [1:0] kind, input int c);
    logic [1:0] ek = it[33:32];
    int lo = int'(it[31:16]);
    int hi = int'(it[15:0]);
    checks++;
    if (ek != kind || c < lo || c > hi) begin
      errors++;
      $display("FAIL %s: got event %0d at cycle %0d, expected event %0d in cycles %0d..%0d",
               name, kind, c, ek, lo, hi);
    end
  endtask

  function automatic logic [W-1:0] pop_main();
    if (exp_q.size() != 0) return exp_q.pop_front();
    return {EV_NONE, 32'd0};
  endfunction

  function automatic logic [W-1:0] pop_min();
    if (exp1_q.size() != 0) return exp1_q.pop_front();
    return {EV_NONE, 32'd0};
  endfunction

  logic prev_level  = 1'b0;
  logic prev_level1 = 1'b0;
  int   last_tick   = -100;
  int   last_tick1  = -100;

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (db_tick) begin
      last_tick = cyc;
      score("main_tick", pop_main(), EV_TICK, cyc);
    end
    if (db_level !== prev_level) begin
      score("main_level", pop_main(), db_level ? EV_RISE : EV_FALL, cyc);
      if (db_level) check("main_tick_align", last_tick, cyc - 1);
    end
    prev_level = db_level;
  end

  // Monitor for the STABLE_TICKS=1 instance.
  always @(negedge clk) begin
    if (db_tick1) begin
      last_tick1 = cyc;
      score("min_tick", pop_min(), EV_TICK, cyc);
    end
    if (db_level1 !== prev_level1) begin
      score("min_level", pop_min(), db_level1 ? EV_RISE : EV_FALL, cyc);
      if (db_level1) check("min_tick_align", last_tick1, cyc - 1);
    end
    prev_level1 = db_level1;
  end

  // Driver tasks
  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_main", exp_q.size(), 0);
    check("drain_min", exp1_q.size(), 0);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Waits until the FSM has seen the input driven at the last next_edge().
  task automatic settle_check(input string name, input int req_state);
    repeat (4) @(negedge clk);
    check(name, int'(st), req_state);
  endtask

  int k;

  initial begin
    // 1. Reset state with sw held high.
    sw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_level", int'(db_level), 0);
      check("rst_tick", int'(db_tick), 0);
      check("rst_state", int'(st), ST_ZERO);
      check("rst_state_min", int'(st1), ST_ZERO);
    end
    next_edge();
    reset = 1'b0;
    k = cyc + 1;
    exp_q.push_back(mk(EV_TICK, k + 18, k + 25));
    exp_q.push_back(mk(EV_RISE, k + 19, k + 26));
    drain(40);
    repeat (20) next_edge();

    // 4. Release with a high glitch during WAIT0, then a clean release.
    next_edge();
    sw = 1'b0;
    settle_check("wait0_entry", ST_WAIT0);
    repeat (3) next_edge();
    sw = 1'b1;
    settle_check("glitch_back_one", ST_ONE);
    next_edge();
    sw = 1'b0;
    k = cyc + 1;
    exp_q.push_back(mk(EV_FALL, k + 19, k + 26));
    drain(40);
    check("release_state", int'(st), ST_ZERO);

    // 2 and 6. Clean press on both instances.
    repeat (5) next_edge();
    sw  = 1'b1;
    sw1 = 1'b1;
    k = cyc + 1;
    exp_q.push_back(mk(EV_TICK, k + 18, k + 25));
    exp_q.push_back(mk(EV_RISE, k + 19, k + 26));
    exp1_q.push_back(mk(EV_TICK, k + 2, k + 9));
    exp1_q.push_back(mk(EV_RISE, k + 3, k + 10));
    drain(40);
    repeat (30) next_edge();
    check("held_level", int'(db_level), 1);

    // Return both instances to 0. A falling acceptance produces no tick.
    sw  = 1'b0;
    sw1 = 1'b0;
    k = cyc + 1;
    exp_q.push_back(mk(EV_FALL, k + 19, k + 26));
    exp1_q.push_back(mk(EV_FALL, k + 3, k + 10));
    drain(40);

    // 3. Bounce rejection: 1,0,1,0 with a 5-cycle dwell, then hold 0.
    for (int i = 0; i < 4; i++) begin
      next_edge();
      sw = (i % 2 == 0) ? 1'b1 : 1'b0;
      settle_check((i % 2 == 0) ? "bounce_wait1" : "bounce_zero",
                   (i % 2 == 0) ? ST_WAIT1 : ST_ZERO);
      @(posedge clk);
    end
    repeat (30) next_edge();
    check("bounce_level", int'(db_level), 0);

    // 5. Reset while in WAIT1 with a partial count.
    sw = 1'b1;
    repeat (12) next_edge();
    check("pre_reset_state", int'(st), ST_WAIT1);
    reset = 1'b1;
    #1;
    check("midrst_state", int'(st), ST_ZERO);
    check("midrst_level", int'(db_level), 0);
    check("midrst_tick", int'(db_tick), 0);
    repeat (2) next_edge();
    reset = 1'b0;
    k = cyc + 1;
    exp_q.push_back(mk(EV_TICK, k + 18, k + 25));
    exp_q.push_back(mk(EV_RISE, k + 19, k + 26));
    drain(40);
    repeat (5) next_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Debounces a raw mechanical switch or pushbutton input and produces the clean `db_level` consumed by the edge-detector stages. The block synchronises the asynchronous input into the `clk` domain. A level change is accepted only after the synchronised input holds stable across `STABLE_TICKS` consecutive ticks of a free-running sample timer. It also provides `db_tick`, a single-cycle Mealy pulse on each accepted rising transition.

## Interface
- `TICK_BITS`, default 20: width of the free-running sample timer. Tick period is 2^TICK_BITS cycles, about 10.5 ms at 100 MHz.
- `STABLE_TICKS`, default 3: number of timer ticks the input must stay stable before a change is accepted. Legal range is 1..15.
- `clk`  input  1: system clock, rising-edge.
- `reset`  input  1: reset, asynchronous, active-high.
- `sw`  input  1: raw switch level, asynchronous to `clk`, may bounce.
- `db_level`  output  1: debounced level.
- `db_tick`  output  1: one-cycle pulse in the cycle the FSM accepts a 0→1 change.

## Operation
- **Synchroniser.** Two flip-flops, `sw` → `s1` → `s_sync`. Both reset to 0. Only `s_sync` is used downstream.
- **Sample timer.** `TICK_BITS`-bit up-counter, reset to 0, free-running and wrapping modulo 2^TICK_BITS.
  - `m_tick` is 1 in the cycle the counter equals 2^TICK_BITS−1.
  - The timer is never cleared by FSM activity.
- **Stability counter `wcnt`.** 4 bits, reset to 0, cleared whenever the FSM enters WAIT1 or WAIT0.
- **FSM states:** ZERO, WAIT1, ONE, WAIT0. Reset state is ZERO.
- **ZERO** (`db_level`=0): if `s_sync`=1, go to WAIT1 and clear `wcnt`.
- **WAIT1** (`db_level`=0):
  - If `s_sync`=0, return to ZERO.
  - Else if `m_tick`=1 and `wcnt`=STABLE_TICKS−1, go to ONE and assert `db_tick` this cycle.
  - Else if `m_tick`=1, increment `wcnt`.
- **ONE** (`db_level`=1): if `s_sync`=0, go to WAIT0 and clear `wcnt`.
- **WAIT0** (`db_level`=1):
  - If `s_sync`=1, return to ONE.
  - Else if `m_tick`=1 and `wcnt`=STABLE_TICKS−1, go to ZERO.
  - Else if `m_tick`=1, increment `wcnt`.
- **Priority.** A bounce (an `s_sync` reversal) takes precedence over `m_tick` in the same cycle: the return transition wins and `wcnt` is discarded.
- **Output decoding.**
  - `db_level` is decoded from the state register only (Moore), so it is glitch-free.
  - `db_tick` is combinational from the state register, `m_tick`, `wcnt` and `s_sync` (Mealy). It is never asserted outside WAIT1.
- **Falling transitions.** No pulse is generated on a 1→0 acceptance.
- **Illegal state encodings** go to ZERO on the next edge.

## Timing
- **Reset values.** While `reset` is high and after release: state ZERO, `db_level`=0, `db_tick`=0, timer=0, `wcnt`=0, `s1`=`s_sync`=0.
- **Reset mid-operation.** Reset in any state, including WAIT1 with a partial count, returns immediately to ZERO. No `db_tick` is issued.
- **Synchroniser latency.** If `sw` is sampled high at edge k, `s_sync`=1 after edge k+1 and the FSM is in WAIT1 after edge k+2.
- **Acceptance latency** for a stable input, with P=2^TICK_BITS and S=STABLE_TICKS:
  - `db_level` changes after edge k+3+(S−1)·P+j, where j∈[0,P−1] is the timer phase.
  - The minimum window is therefore (S−1)·P+1 cycles of stability after entry to WAIT1.
- **`db_tick` alignment.** `db_tick` is high for exactly the one cycle immediately preceding the edge at which `db_level` rises.
- **Short pulses.** A pulse on `sw` shorter than (S−1)·P+1 cycles never changes `db_level`.
- **Timer wrap.** Wrap from all-ones to 0 is silent. The timer keeps its phase across FSM transitions.
- **`STABLE_TICKS`=1.** Acceptance occurs on the first `m_tick` after entering WAIT, i.e. 1..P cycles.

## Test plan
All scenarios use TICK_BITS=3 (P=8) and STABLE_TICKS=3 unless stated otherwise.

1. **Reset state.** Assert reset for 3 cycles with `sw`=1, then release → `db_level`=0 and `db_tick`=0 throughout reset. `db_level` rises 19..26 edges after the first post-reset edge sampling `sw`=1.
2. **Clean press.** `sw` goes 0→1 at edge 40 and is held → `db_level`=1 within edges 59..66. `db_tick` is high for exactly one cycle, immediately before the rise. No further pulses while held.
3. **Bounce rejection.** Toggle `sw` 1,0,1,0 with 5-cycle dwell each, then hold 0 → `db_level` stays 0 and `db_tick` never asserts. The FSM alternates ZERO/WAIT1.
4. **Clean release.** From `db_level`=1, drop `sw` to 0 and hold → `db_level`=0 within 19..26 edges, and `db_tick` stays 0. Then insert a 4-cycle high glitch while in WAIT0 → FSM returns to ONE and restarts the count.
5. **Reset mid-wait.** Raise `sw`, then assert reset 12 cycles later while in WAIT1 → immediate ZERO, `db_level`=0, no `db_tick`. After release the full 19..26 window applies again.
6. **Minimum stability count.** STABLE_TICKS=1, `sw` rises at edge 10 → `db_level`=1 within edges 13..20 and `db_tick` fires once.
